// File: rtl/alu_ops_pkg.sv
// Shared ALU op-code encodings and the multicycle ALU state encoding.
// Imported by the ALU control unit and the execute-stage ALU.
package alu_ops_pkg;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_NOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_LUI     = 4'b0101;
  localparam logic [3:0] OP_SLL     = 4'b0111;
  localparam logic [3:0] OP_SRL     = 4'b1000;
  localparam logic [3:0] OP_ILLEGAL = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_logic_core.sv
// Single-cycle ALU datapath: AND/OR/NOR/ADD/LUI, pass-B for zero-length
// shifts, and detection of unsupported op codes (which yield zero).
module alu_logic_core
  import alu_ops_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOR: result = ~(a | b);
      OP_ADD: result = a + b;
      OP_LUI: result = {b[15:0], {(DATA_WIDTH-16){1'b0}}};
      // A shift only reaches this core when its amount is zero.
      OP_SLL, OP_SRL: result = b;
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: logic/add/LUI finish in one cycle, SLL/SRL iterate one
// bit per cycle. Handshake: a request is taken on a clock edge where
// ready=1 and start=1; done pulses for one cycle when ALUResult/Zero/IllegalOp
// are fresh; start while ready=0 is dropped, never queued.
module multicycle_alu
  import alu_ops_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   ready,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   IllegalOp,
  output alu_state_t             state_dbg
);

  alu_state_t             state;
  logic [DATA_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]  acc_next;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   dir_right;
  logic [DATA_WIDTH-1:0]  core_result;
  logic                   core_illegal;

  alu_logic_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .op      (ALUOperation),
    .a       (A),
    .b       (B),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign acc_next  = dir_right ? (acc >> 1) : (acc << 1);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      IllegalOp <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      dir_right <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ready <= 1'b0;
            if (is_shift(ALUOperation) && (shamt != '0)) begin
              acc       <= B;
              cnt       <= shamt;
              dir_right <= (ALUOperation == OP_SRL);
              IllegalOp <= 1'b0;
              state     <= ST_SHIFT;
            end else begin
              ALUResult <= core_result;
              Zero      <= (core_result == '0);
              IllegalOp <= core_illegal;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHAMT_WIDTH'(1);
          // Publish only on the last step so ALUResult never shows a partial shift.
          if (cnt == SHAMT_WIDTH'(1)) begin
            ALUResult <= acc_next;
            Zero      <= (acc_next == '0);
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
